// File: rtl/pipe_pkg.sv
// Shared definitions for the ID/EX pipeline stage: default field widths and the
// prioritised stage-control encoding.
package pipe_pkg;

  localparam int unsigned DataWDef  = 16;
  localparam int unsigned RaddrWDef = 3;
  localparam int unsigned AluopWDef = 4;
  localparam int unsigned CntWDef   = 8;

  typedef enum logic [1:0] {
    CTL_NORMAL = 2'd0,
    CTL_BUBBLE = 2'd1,
    CTL_HOLD   = 2'd2,
    CTL_FLUSH  = 2'd3
  } ctl_e;

  // Collapse the three raw controls into one action: flush > hold > bubble > normal.
  function automatic ctl_e ctl_sel(input logic flush, input logic hold, input logic bubble);
    ctl_e ctl;
    if (flush) begin
      ctl = CTL_FLUSH;
    end else if (hold) begin
      ctl = CTL_HOLD;
    end else if (bubble) begin
      ctl = CTL_BUBBLE;
    end else begin
      ctl = CTL_NORMAL;
    end
    return ctl;
  endfunction

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// Decode-to-execute bundle: decode-side fields and stage controls in, execute-side
// registered fields, hazard flag and profiling counters out.
interface id_ex_pipe_reg_if #(
  parameter int unsigned DATA_W  = pipe_pkg::DataWDef,
  parameter int unsigned RADDR_W = pipe_pkg::RaddrWDef,
  parameter int unsigned ALUOP_W = pipe_pkg::AluopWDef,
  parameter int unsigned CNT_W   = pipe_pkg::CntWDef
);

  logic               flush;
  logic               hold;
  logic               bubble;

  logic               id_valid;
  logic [ALUOP_W-1:0] id_alu_op;
  logic               id_wb;
  logic               id_ext_mem;
  logic               id_wmem;
  logic               id_load;
  logic [DATA_W-1:0]  id_r1;
  logic [DATA_W-1:0]  id_r2;
  logic [DATA_W-1:0]  id_wd_mem;
  logic [RADDR_W-1:0] id_rd;
  logic [RADDR_W-1:0] id_rs;
  logic [RADDR_W-1:0] id_rt;

  logic               ex_valid;
  logic [ALUOP_W-1:0] ex_alu_op;
  logic               ex_wb;
  logic               ex_ext_mem;
  logic               ex_wmem;
  logic               ex_load;
  logic [DATA_W-1:0]  ex_r1;
  logic [DATA_W-1:0]  ex_r2;
  logic [DATA_W-1:0]  ex_wd_mem;
  logic [RADDR_W-1:0] ex_rd;
  logic [RADDR_W-1:0] ex_rs;
  logic [RADDR_W-1:0] ex_rt;

  logic               load_use_hazard;
  logic [CNT_W-1:0]   bubble_cnt;
  logic [CNT_W-1:0]   hold_cnt;

  modport master (
    output flush, hold, bubble,
    output id_valid, id_alu_op, id_wb, id_ext_mem, id_wmem, id_load,
    output id_r1, id_r2, id_wd_mem, id_rd, id_rs, id_rt,
    input  ex_valid, ex_alu_op, ex_wb, ex_ext_mem, ex_wmem, ex_load,
    input  ex_r1, ex_r2, ex_wd_mem, ex_rd, ex_rs, ex_rt,
    input  load_use_hazard, bubble_cnt, hold_cnt
  );

  modport slave (
    input  flush, hold, bubble,
    input  id_valid, id_alu_op, id_wb, id_ext_mem, id_wmem, id_load,
    input  id_r1, id_r2, id_wd_mem, id_rd, id_rs, id_rt,
    output ex_valid, ex_alu_op, ex_wb, ex_ext_mem, ex_wmem, ex_load,
    output ex_r1, ex_r2, ex_wd_mem, ex_rd, ex_rs, ex_rt,
    output load_use_hazard, bubble_cnt, hold_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with prioritised flush/hold/bubble, write-enable gating by
// valid, load-use hazard detection and saturating stall profiling counters.
module id_ex_pipe_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W       = DataWDef,
  parameter int unsigned RADDR_W      = RaddrWDef,
  parameter int unsigned ALUOP_W      = AluopWDef,
  parameter int unsigned CNT_W        = CntWDef,
  parameter bit          R0_HARDWIRED = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  id_ex_pipe_reg_if.slave bus
);

  ctl_e ctl;

  logic               valid_q,   valid_d;
  logic [ALUOP_W-1:0] alu_op_q,  alu_op_d;
  logic               wb_q,      wb_d;
  logic               ext_mem_q, ext_mem_d;
  logic               wmem_q,    wmem_d;
  logic               load_q,    load_d;
  logic [DATA_W-1:0]  r1_q,      r1_d;
  logic [DATA_W-1:0]  r2_q,      r2_d;
  logic [DATA_W-1:0]  wd_mem_q,  wd_mem_d;
  logic [RADDR_W-1:0] rd_q,      rd_d;
  logic [RADDR_W-1:0] rs_q,      rs_d;
  logic [RADDR_W-1:0] rt_q,      rt_d;

  assign ctl = ctl_sel(bus.flush, bus.hold, bus.bubble);

  always_comb begin
    valid_d   = valid_q;
    alu_op_d  = alu_op_q;
    wb_d      = wb_q;
    ext_mem_d = ext_mem_q;
    wmem_d    = wmem_q;
    load_d    = load_q;
    r1_d      = r1_q;
    r2_d      = r2_q;
    wd_mem_d  = wd_mem_q;
    rd_d      = rd_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    unique case (ctl)
      CTL_FLUSH: begin
        valid_d   = 1'b0;
        alu_op_d  = '0;
        wb_d      = 1'b0;
        ext_mem_d = 1'b0;
        wmem_d    = 1'b0;
        load_d    = 1'b0;
        r1_d      = '0;
        r2_d      = '0;
        wd_mem_d  = '0;
        rd_d      = '0;
        rs_d      = '0;
        rt_d      = '0;
      end
      CTL_HOLD: begin
      end
      // A bubble still latches the data path; only the side-effecting enables die.
      CTL_BUBBLE: begin
        valid_d   = 1'b0;
        alu_op_d  = bus.id_alu_op;
        wb_d      = 1'b0;
        ext_mem_d = bus.id_ext_mem;
        wmem_d    = 1'b0;
        load_d    = 1'b0;
        r1_d      = bus.id_r1;
        r2_d      = bus.id_r2;
        wd_mem_d  = bus.id_wd_mem;
        rd_d      = bus.id_rd;
        rs_d      = bus.id_rs;
        rt_d      = bus.id_rt;
      end
      CTL_NORMAL: begin
        valid_d   = bus.id_valid;
        alu_op_d  = bus.id_alu_op;
        wb_d      = bus.id_wb & bus.id_valid;
        ext_mem_d = bus.id_ext_mem;
        wmem_d    = bus.id_wmem & bus.id_valid;
        load_d    = bus.id_load & bus.id_valid;
        r1_d      = bus.id_r1;
        r2_d      = bus.id_r2;
        wd_mem_d  = bus.id_wd_mem;
        rd_d      = bus.id_rd;
        rs_d      = bus.id_rs;
        rt_d      = bus.id_rt;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      alu_op_q  <= '0;
      wb_q      <= 1'b0;
      ext_mem_q <= 1'b0;
      wmem_q    <= 1'b0;
      load_q    <= 1'b0;
      r1_q      <= '0;
      r2_q      <= '0;
      wd_mem_q  <= '0;
      rd_q      <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
    end else begin
      valid_q   <= valid_d;
      alu_op_q  <= alu_op_d;
      wb_q      <= wb_d;
      ext_mem_q <= ext_mem_d;
      wmem_q    <= wmem_d;
      load_q    <= load_d;
      r1_q      <= r1_d;
      r2_q      <= r2_d;
      wd_mem_q  <= wd_mem_d;
      rd_q      <= rd_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
    end
  end

  assign bus.ex_valid   = valid_q;
  assign bus.ex_alu_op  = alu_op_q;
  assign bus.ex_wb      = wb_q;
  assign bus.ex_ext_mem = ext_mem_q;
  assign bus.ex_wmem    = wmem_q;
  assign bus.ex_load    = load_q;
  assign bus.ex_r1      = r1_q;
  assign bus.ex_r2      = r2_q;
  assign bus.ex_wd_mem  = wd_mem_q;
  assign bus.ex_rd      = rd_q;
  assign bus.ex_rs      = rs_q;
  assign bus.ex_rt      = rt_q;

  // Ungated by stage controls: the hazard unit turns this straight back into bubble.
  logic rd_match;
  logic rd_is_r0;
  assign rd_match = (rd_q == bus.id_rs) || (rd_q == bus.id_rt);
  assign rd_is_r0 = (rd_q == '0);
  assign bus.load_use_hazard = bus.id_valid & valid_q & load_q & wb_q & rd_match
                               & ~(R0_HARDWIRED & rd_is_r0);

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_bubble_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (ctl == CTL_BUBBLE),
    .cnt  (bus.bubble_cnt)
  );

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_hold_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (ctl == CTL_HOLD),
    .cnt  (bus.hold_cnt)
  );

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
Parametrised ID/EX pipeline register for the 16-bit MIPS-style core, the next generation of the decode-to-execute latch. It adds an asynchronous active-low reset, a per-stage valid bit, and prioritised flush, hold and bubble controls in place of the old 2-bit stall code. It also provides combinational load-use hazard detection against the instruction in decode, plus saturating bubble and hold event counters for pipeline profiling.

Parameters:
DATA_W, 16, width of register operands and memory write data
RADDR_W, 3, register-file address width (rd/rs/rt)
ALUOP_W, 4, ALU control signal width
CNT_W, 8, width of each saturating event counter
R0_HARDWIRED, 1, when 1, rd==0 never raises a hazard (register 0 is constant)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  kill the entry being captured (branch/jump redirect)
hold  in  1  freeze the stage (downstream stall)
bubble  in  1  capture a bubble (hazard stall from hazard unit)
id_valid  in  1  decode-stage instruction valid
id_alu_op  in  ALUOP_W  ALU control
id_wb, id_ext_mem, id_wmem, id_load  in  1 each  writeback, extend-for-mem, memory write, load
id_r1, id_r2, id_wd_mem  in  DATA_W each  operand 1, operand 2, memory write data
id_rd, id_rs, id_rt  in  RADDR_W each  register addresses
ex_valid  out  1  execute-stage entry valid
ex_alu_op, ex_wb, ex_ext_mem, ex_wmem, ex_load, ex_r1, ex_r2, ex_wd_mem, ex_rd, ex_rs, ex_rt  out  (widths as inputs)  registered copies
load_use_hazard  out  1  combinational: decode instr depends on a load in EX
bubble_cnt  out  CNT_W  saturating count of bubble cycles
hold_cnt  out  CNT_W  saturating count of hold cycles

Behaviour:
- Reset (rst_n=0, async): every output register to 0, including ex_valid, both counters. Reset mid-operation discards the entry; first capture is on the first rising edge with rst_n=1.
- Latency 1 cycle, ID to EX.
- Per-edge priority: flush > hold > bubble > normal.
- flush: all ex_* outputs and ex_valid to 0. Counters unchanged.
- hold (no flush): every ex_* and ex_valid keeps its value. hold_cnt+1.
- bubble (no flush, no hold): data fields (alu_op, r1, r2, wd_mem, rd, rs, rt, ext_mem) captured from id_*. ex_wb, ex_wmem, ex_load, ex_valid forced to 0, so RF and memory are never written. bubble_cnt+1.
- normal: all fields captured; ex_valid=id_valid. ex_wb, ex_wmem, ex_load = id_* AND id_valid, so invalid entries never carry write enables.
- Counters saturate at 2^CNT_W-1 and never wrap.
- hold and bubble both high: only hold_cnt increments.
- load_use_hazard = id_valid & ex_valid & ex_load & ex_wb & (ex_rd==id_rs | ex_rd==id_rt) & !(R0_HARDWIRED & ex_rd==0). Purely combinational, not gated by flush/hold/bubble; the hazard unit feeds it back as bubble.

Decomposition:
- Shared package pipe_pkg: ALUOP_W/RADDR_W/DATA_W defaults, stage-control priority encoding constants (CTL_NORMAL, CTL_BUBBLE, CTL_HOLD, CTL_FLUSH).
- One sub-module: sat_counter (CNT_W parameter, inc input, async active-low reset), instantiated twice.

Test Plan:
- Reset: drive nonzero id_*, assert rst_n=0 between edges -> all outputs 0 immediately; release, one edge -> ex_r1=id_r1 (e.g. 16'h1234), ex_valid=1.
- Normal flow: id_valid=1, id_wb=1, id_rd=3, id_alu_op=4'h5 -> next edge ex_wb=1, ex_rd=3, ex_alu_op=5. Same inputs with id_valid=0 -> ex_wb=0, ex_valid=0.
- Bubble: bubble=1 with id_wb=1, id_wmem=1, id_r2=16'hBEEF -> ex_r2=16'hBEEF, ex_wb=0, ex_wmem=0, ex_valid=0, bubble_cnt=1.
- Hold/priority: load entry, then hold=1 for 3 edges with changing id_* -> outputs unchanged, hold_cnt=3. hold+bubble -> hold_cnt+1, bubble_cnt unchanged. flush+hold -> all 0.
- Load-use: EX holds load rd=2 wb=1 valid=1; id_rs=2 -> load_use_hazard=1; id_rs=id_rt=5 -> 0; rd=0 with R0_HARDWIRED=1 -> 0.
- Saturation: CNT_W=2, bubble for 5 edges -> bubble_cnt=3 and stays 3.
